// File: rtl/alu_srcb_sequencer.sv
// Control sequencer for the ALU source-B select. It accepts 9-bit instructions over a
// valid/ready handshake, then runs an EXEC -> WB cycle pair for each operation. Increment and
// decrement can be repeated in hardware.
module alu_srcb_sequencer #(
  parameter int unsigned REP_W = 3
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       instr_valid,
  input  logic [8:0] instr_in,
  output logic       instr_ready,
  input  logic       hold,
  output logic [1:0] Sel_SrcB,
  output logic [7:0] immd_out,
  output logic       alu_en,
  output logic       reg_we,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e           state_q;
  logic [REP_W-1:0] cnt_q;
  logic             nop_q;

  logic [2:0]       opcode;
  logic [1:0]       dec_sel;
  logic             dec_load_sel;
  logic             dec_load_imm;
  logic             dec_nop;
  logic [REP_W-1:0] dec_cnt;

  assign opcode = instr_in[8:6];

  // Decode the incoming instruction. Opcodes 110/111 fall through to NOP.
  always_comb begin
    dec_sel      = 2'b00;
    dec_load_sel = 1'b0;
    dec_load_imm = 1'b0;
    dec_nop      = 1'b0;
    dec_cnt      = '0;
    case (opcode)
      3'b000: begin
        dec_sel      = 2'b00;
        dec_load_sel = 1'b1;
      end
      3'b001: begin
        dec_sel      = 2'b01;
        dec_load_sel = 1'b1;
      end
      3'b010: begin
        dec_sel      = 2'b10;
        dec_load_sel = 1'b1;
      end
      3'b011: begin
        dec_sel      = 2'b11;
        dec_load_sel = 1'b1;
        dec_load_imm = 1'b1;
      end
      3'b100: begin
        dec_sel      = 2'b00;
        dec_load_sel = 1'b1;
        dec_cnt      = instr_in[REP_W-1:0];
      end
      3'b101: begin
        dec_sel      = 2'b01;
        dec_load_sel = 1'b1;
        dec_cnt      = instr_in[REP_W-1:0];
      end
      default: dec_nop = 1'b1;
    endcase
  end

  // Sequencer FSM with all outputs registered. hold freezes everything outside IDLE.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      nop_q       <= 1'b0;
      instr_ready <= 1'b1;
      Sel_SrcB    <= 2'b00;
      immd_out    <= 8'h00;
      alu_en      <= 1'b0;
      reg_we      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (instr_valid && instr_ready) begin
            // NOP leaves the selects untouched; they only change on a real operation.
            if (dec_load_sel) Sel_SrcB <= dec_sel;
            if (dec_load_imm) immd_out <= {{2{instr_in[5]}}, instr_in[5:0]};
            cnt_q       <= dec_cnt;
            nop_q       <= dec_nop;
            alu_en      <= !dec_nop;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state_q     <= StExec;
          end
        end
        StExec: begin
          if (!hold) begin
            alu_en  <= 1'b0;
            reg_we  <= !nop_q;
            done    <= (cnt_q == '0);
            state_q <= StWb;
          end
        end
        StWb: begin
          if (!hold) begin
            reg_we <= 1'b0;
            done   <= 1'b0;
            if (cnt_q == '0) begin
              instr_ready <= 1'b1;
              busy        <= 1'b0;
              state_q     <= StIdle;
            end else begin
              cnt_q   <= cnt_q - 1'b1;
              alu_en  <= !nop_q;
              state_q <= StExec;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/alu_srcb_sequencer.md
Name: alu_srcb_sequencer

Overview:
- Multi-cycle control FSM on the producing side of the ALU source-B select interface.
- Accepts 9-bit instructions over a valid/ready handshake and decodes them.
- For each operation it drives Sel_SrcB[1:0] and the 8-bit immediate: 00 = +1, 01 = −1, 10 = treg, 11 = immediate.
- Sequences ALU-enable and register write-back, including hardware-repeated increment/decrement.

Parameters:
- REP_W, 3, width of the repeat-count field in the instruction; repeat count = field+1, range 1..2^REP_W.

Ports:
- CLK  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  instr_in holds a valid instruction.
- instr_in  input  9  [8:6] opcode, [5:0] operand.
- instr_ready  output  1  sequencer can accept an instruction.
- hold  input  1  stall; freezes the FSM in EXEC/WB.
- Sel_SrcB  output  2  ALU source-B select.
- immd_out  output  8  sign-extended immediate.
- alu_en  output  1  ALU result valid this cycle.
- reg_we  output  1  register-file write strobe.
- busy  output  1  not IDLE.
- done  output  1  one-cycle pulse on the final write-back of an instruction.

Behaviour:
- Clock and reset: one clock, CLK. reset_n is asynchronous, active-low.
- Reset values (all outputs registered): state=IDLE, instr_ready=1, Sel_SrcB=2'b00, immd_out=8'h00, alu_en=0, reg_we=0, busy=0, done=0, repeat counter=0.
- Opcodes:
  - 000 INC → Sel_SrcB 00.
  - 001 DEC → Sel_SrcB 01.
  - 010 ADDT → Sel_SrcB 10.
  - 011 ADDI → Sel_SrcB 11, immd_out = {{2{op[5]}}, op[5:0]}.
  - 100 REPINC → Sel_SrcB 00, repeat op[REP_W-1:0]+1 times.
  - 101 REPDEC → Sel_SrcB 01, repeat op[REP_W-1:0]+1 times.
  - 110/111 NOP.
- States: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1, busy=0.
  - On the edge where instr_valid & instr_ready: latch the instruction, load Sel_SrcB/immd_out, load the repeat counter (0 for non-REP), go to EXEC.
  - instr_ready deasserts on the same edge.
- EXEC:
  - alu_en=1 for one cycle (0 for NOP); Sel_SrcB and immd_out stable.
  - → WB.
- WB:
  - reg_we=1 for one cycle (0 for NOP).
  - If counter==0: done=1, → IDLE, instr_ready=1 on the following cycle.
  - Else: counter−1, → EXEC.
- Latency:
  - Accept at edge k → alu_en high in cycle k+1, reg_we/done high in cycle k+2, instr_ready high in cycle k+3.
  - A REP op with count N takes 2N cycles from accept to done; done pulses only on the last WB.
- Selects never change while busy: Sel_SrcB and immd_out hold from accept until the next accept. They retain their last value in IDLE.
- hold:
  - When hold=1 in EXEC or WB, state, counter and all outputs freeze, including the alu_en/reg_we levels.
  - The pulse is not repeated after release: alu_en/reg_we/done stay high across the stall, then behave as one logical cycle.
  - hold is ignored in IDLE.
- instr_valid while busy is ignored; the instruction is not consumed and the producer must keep it until instr_ready.
- Counter wrap: the counter never underflows; counter==0 in WB always terminates.
- Reset mid-operation:
  - Immediate return to IDLE with the reset values above; no partial reg_we or done.
  - The pending repeat count is discarded.
- Unknown opcode bits are never X-propagated; 110/111 decode as NOP (done pulses, reg_we=0, alu_en=0).

Test Plan:
- Reset then INC (9'b000_000000) with valid held → Sel_SrcB=00; alu_en at k+1; reg_we and done at k+2; instr_ready back at k+3.
- ADDI operand 6'b111101 → Sel_SrcB=11, immd_out=8'hFD; ADDI 6'b000101 → immd_out=8'h05.
- REPDEC count field 3'b011 → Sel_SrcB=01; four alu_en/reg_we pairs over 8 cycles; exactly one done, at the 4th reg_we; instr_ready=0 throughout.
- Back-to-back ADDT and NOP with instr_valid held → second instruction accepted only when instr_ready=1; NOP gives done with reg_we=0 and alu_en=0; Sel_SrcB stays 10 through the NOP.
- REPINC count 7 (8 iterations), hold=1 for 3 cycles during the 2nd WB → reg_we stays high 4 cycles; total reg_we count still 8; done once.
- Assert reset_n=0 asynchronously mid-REPINC (between edges) → outputs immediately at reset values; after release, a new INC completes normally with a single done.
